plic_irq_gateway: RTL
=====================

# plic_irq_gateway

Per-source interrupt gateway for the RV64 platform PLIC. It synchronises raw interrupt lines and applies level or edge-trigger semantics per source. It tracks the claim/complete lifecycle of each source and produces the pending vector. That vector feeds the hardware-write side (`de`/`d`) of the RO pending-register slices; the LE (trigger-mode) register slices feed it.

## Interface
Parameters:
- `N_SOURCE`, 32, number of interrupt sources (1..255).
- `SYNC_STAGES`, 2, input synchroniser depth (0 = bypass; sources already on `clk_i`).

Ports:
- `clk_i`  in  1  single clock.
- `rst_ni`  in  1  reset: asynchronous, active-low.
- `src_i`  in  N_SOURCE  raw interrupt lines, asynchronous unless `SYNC_STAGES` = 0.
- `le_i`  in  N_SOURCE  trigger mode per source (1 = rising edge, 0 = active-high level); from LE register `q`.
- `claim_i`  in  N_SOURCE  one-cycle claim pulse, at most one bit set per cycle.
- `complete_i`  in  N_SOURCE  one-cycle completion pulse, at most one bit set per cycle.
- `ip_o`  out  N_SOURCE  pending per source.
- `ia_o`  out  N_SOURCE  active per source: pending or in service.
- `hw_de_o`  out  1  pending-register update strobe.
- `hw_d_o`  out  N_SOURCE  pending-register update data (= `ip_o`).

## Operation
- Synchroniser output `s[i]` resets to 0. `s_q` is the previous-cycle copy of `s` and resets to 0.
- Set request: `set_req[i] = le_i[i] ? (s & ~s_q) : s`.
- Each source has a 3-state FSM. `IDLE` gives ip=0, ia=0. `PEND` gives ip=1, ia=1. `ACTIVE` gives ip=0, ia=1.
  - `IDLE`, on `set_req` → `PEND`.
  - `PEND`, on `claim_i` → `ACTIVE`. Further set requests are coalesced and dropped.
  - `ACTIVE`, on rising edge (le=1) → sets the one-deep `held[i]` flag. Level requests are ignored.
  - `ACTIVE`, on `complete_i`: if `held[i]` → `PEND` and clear `held`; else → `IDLE`.
- Ignored pulses:
  - `claim_i` in `IDLE` or `ACTIVE` is ignored.
  - `complete_i` in `IDLE` or `PEND` is ignored.
- A still-asserted level source re-pends one cycle after returning to `IDLE`. This is by design: the handler must deassert the device before complete.
- Simultaneous events:
  - `ACTIVE` with complete and a new edge in the same cycle: the edge counts as held, so the next state is `PEND`.
  - `IDLE` with set_req: always → `PEND`.
- `le_i[i]` change takes effect on the next cycle's `set_req`. `held[i]` is cleared whenever `le_i[i]` = 0.
- `hw_de_o` is a registered flag. It is high in every cycle in which `ip_o` differs from its previous-cycle value. `hw_d_o` = `ip_o`, so the pending register `q` tracks `ip_o` with one cycle of lag.

## Timing
- Reset (async assert, synchronous release via the system reset synchroniser):
  - All FSMs go to `IDLE`; `held`, `s`, `s_q` go to 0.
  - `ip_o`, `ia_o`, `hw_d_o` = 0; `hw_de_o` = 0.
- Reset mid-service drops all pending, active and held state. No completion is required afterwards.
- Edge-mode source already high at reset release: seen as one rising edge, pends after sync latency.
- Latency, `src_i` rise to `ip_o` = 1: `SYNC_STAGES` + 1 cycles, i.e. 3 for the default.
- Latency, `ip_o` change to `hw_de_o`: the same cycle. Pending register `q` follows at +1.
- Claim pulse in cycle t: `ip_o` = 0 at t+1.
- Complete pulse in cycle t: `ia_o` = 0 at t+1, or `ip_o` = 1 at t+1 if `held` was set.
- Pulses on a source are not required to be spaced; each cycle is evaluated independently.

## Structure
- Package `plic_gw_pkg`: `gw_state_e` enum (`GW_IDLE`, `GW_PEND`, `GW_ACTIVE`, 2-bit) and the `MAX_SOURCE` constant = 255.
- Sub-module `prim_flop_2sync` (parameterised width and depth, async active-low reset to 0). It is instantiated once for the whole `src_i` vector and bypassed when `SYNC_STAGES` = 0.
- Per-source FSM, `held` and `s_q` are in a generate loop. `hw_de_o` comparison logic is at top level.

## Test plan
- Level, src[3]=1, le=0: `ip_o[3]`=1 at +3 cycles. `hw_de_o`=1 that cycle. claim[3] → ip=0, ia=1. src low, complete[3] → ia=0 next cycle.
- Level, src[3] held high through complete: `IDLE` for one cycle, then `ip_o[3]`=1 again.
- Edge, le[5]=1, pulse src[5] twice while `PEND`: only one claim is needed; after complete → `IDLE`.
- Edge during `ACTIVE` on src[5], including one coincident with the complete pulse: after complete, `ip_o[5]`=1 next cycle.
- Claim in `IDLE`, complete in `PEND`, and claim on an unpended source: no state change and no `hw_de_o`.
- Reset asserted while sources 0 and 7 are `ACTIVE`/`PEND` with `held` set: all outputs 0 immediately (asynchronous). After release, an edge-mode source already high pends at +3 cycles.

Source files
------------

// File: rtl/plic_gw_pkg.sv
// Shared types and constants for the PLIC interrupt gateway.
package plic_gw_pkg;

  // Upper bound on the number of interrupt sources a gateway instance may serve.
  localparam int unsigned MAX_SOURCE = 255;

  // Per-source lifecycle: waiting, pending (visible to the target), in service.
  typedef enum logic [1:0] {
    GW_IDLE   = 2'd0,
    GW_PEND   = 2'd1,
    GW_ACTIVE = 2'd2
  } gw_state_e;

  // Pending bit presented to the pending register for a given lifecycle state.
  function automatic logic gw_ip(gw_state_e st);
    return (st == GW_PEND);
  endfunction

  // Active bit: pending or still being serviced.
  function automatic logic gw_ia(gw_state_e st);
    return (st != GW_IDLE);
  endfunction

endpackage

// File: rtl/prim_flop_2sync.sv
// Multi-stage flop synchroniser for a bus of independent single-bit signals.
module prim_flop_2sync #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] r_stage [Depth];

  // Shift the raw input through Depth flop stages; all stages reset to 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < Depth; k++) begin
        r_stage[k] <= '0;
      end
    end else begin
      r_stage[0] <= d_i;
      for (int k = 1; k < Depth; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
    end
  end

  assign q_o = r_stage[Depth-1];

endmodule

// File: rtl/plic_irq_gateway.sv
// Per-source PLIC interrupt gateway: synchronises raw lines, applies level or
// rising-edge semantics, tracks claim/complete and drives the pending register.
module plic_irq_gateway
  import plic_gw_pkg::*;
#(
  parameter int unsigned N_SOURCE    = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [N_SOURCE-1:0] src_i,
  input  logic [N_SOURCE-1:0] le_i,
  input  logic [N_SOURCE-1:0] claim_i,
  input  logic [N_SOURCE-1:0] complete_i,
  output logic [N_SOURCE-1:0] ip_o,
  output logic [N_SOURCE-1:0] ia_o,
  output logic                hw_de_o,
  output logic [N_SOURCE-1:0] hw_d_o
);

  if (N_SOURCE == 0 || N_SOURCE > MAX_SOURCE) begin : g_param_check
    $error("plic_irq_gateway: N_SOURCE out of range");
  end

  logic [N_SOURCE-1:0] w_s;     // synchronised source levels
  logic [N_SOURCE-1:0] w_ip;    // current pending vector
  logic [N_SOURCE-1:0] w_ia;    // current active vector
  logic [N_SOURCE-1:0] w_ip_d;  // pending vector after this edge
  logic                r_hw_de;

  // Sources already on clk_i skip the synchroniser entirely.
  if (SYNC_STAGES == 0) begin : g_sync_bypass
    assign w_s = src_i;
  end else begin : g_sync
    prim_flop_2sync #(
      .Width (N_SOURCE),
      .Depth (SYNC_STAGES)
    ) u_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (src_i),
      .q_o    (w_s)
    );
  end

  for (genvar i = 0; i < N_SOURCE; i++) begin : g_src
    gw_state_e r_state;
    gw_state_e w_state_d;
    logic      r_held;
    logic      w_held_d;
    logic      r_s_q;
    logic      w_rise;
    logic      w_edge;
    logic      w_set_req;
    logic      w_held_eff;

    assign w_rise     = w_s[i] & ~r_s_q;
    assign w_edge     = le_i[i] & w_rise;
    assign w_set_req  = le_i[i] ? w_rise : w_s[i];
    // A held edge only survives while the source stays in edge mode.
    assign w_held_eff = r_held & le_i[i];

    // Register lifecycle state, held-edge flag and previous synchronised level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_state <= GW_IDLE;
        r_held  <= 1'b0;
        r_s_q   <= 1'b0;
      end else begin
        r_state <= w_state_d;
        r_held  <= w_held_d;
        r_s_q   <= w_s[i];
      end
    end

    // Lifecycle transitions; unrelated claim/complete pulses leave state unchanged.
    always_comb begin
      w_state_d = r_state;
      w_held_d  = r_held;
      unique case (r_state)
        GW_IDLE: begin
          if (w_set_req) begin
            w_state_d = GW_PEND;
          end
        end
        GW_PEND: begin
          // New requests while pending coalesce into the one already pending.
          if (claim_i[i]) begin
            w_state_d = GW_ACTIVE;
          end
        end
        GW_ACTIVE: begin
          if (complete_i[i]) begin
            // An edge arriving with the complete pulse counts as held.
            w_state_d = (w_held_eff || w_edge) ? GW_PEND : GW_IDLE;
            w_held_d  = 1'b0;
          end else if (w_edge) begin
            w_held_d = 1'b1;
          end
        end
        default: begin
          w_state_d = GW_IDLE;
          w_held_d  = 1'b0;
        end
      endcase
      if (!le_i[i]) begin
        w_held_d = 1'b0;
      end
    end

    assign w_ip[i]   = gw_ip(r_state);
    assign w_ia[i]   = gw_ia(r_state);
    assign w_ip_d[i] = gw_ip(w_state_d);
  end

  // Strobe the pending register in the same cycle the pending vector changes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hw_de <= 1'b0;
    end else begin
      r_hw_de <= (w_ip_d != w_ip);
    end
  end

  assign ip_o    = w_ip;
  assign ia_o    = w_ia;
  assign hw_d_o  = w_ip;
  assign hw_de_o = r_hw_de;

endmodule
